// File: rtl/mux_scan_capture_if.sv
// mux_scan_capture_if: control, mux data and result signals of the scan capture block.
interface mux_scan_capture_if;
   logic       start;
   logic       cont;
   logic       abort;
   logic       mux_o;
   logic [2:0] sel;
   logic       busy;
   logic [7:0] word;
   logic       word_valid;
   logic [7:0] scan_cnt;
   modport master (output start, cont, abort, mux_o, input sel, busy, word, word_valid, scan_cnt);
   modport slave  (input start, cont, abort, mux_o, output sel, busy, word, word_valid, scan_cnt);
endinterface

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps an 8-to-1 mux select through 0..7, sampling mux_o per bit
// after SETTLE wait cycles, and publishes the assembled byte as word.
module mux_scan_capture #(
   parameter int SETTLE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_scan_capture_if.slave     bus
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;
   localparam logic [3:0] L_SETTLE = 4'(SETTLE);
   localparam state_t     L_FIRST  = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
   state_t     r_state, w_state;
   logic [2:0] r_sel, w_sel;
   logic       r_busy, w_busy;
   logic [3:0] r_cnt, w_cnt;
   logic [7:0] r_shadow, w_shadow;
   logic [7:0] r_word, w_word;
   logic       r_valid, w_valid;
   logic [7:0] r_scan, w_scan;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sel    <= '0;
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_word   <= '0;
         r_valid  <= 1'b0;
         r_scan   <= '0;
      end else begin
         r_state  <= w_state;
         r_sel    <= w_sel;
         r_busy   <= w_busy;
         r_cnt    <= w_cnt;
         r_shadow <= w_shadow;
         r_word   <= w_word;
         r_valid  <= w_valid;
         r_scan   <= w_scan;
      end
   end
   always_comb begin
      w_state  = r_state;
      w_sel    = r_sel;
      w_busy   = r_busy;
      w_cnt    = r_cnt;
      w_shadow = r_shadow;
      w_word   = r_word;
      w_valid  = 1'b0;
      w_scan   = r_scan;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               w_state  = L_FIRST;
               w_sel    = '0;
               w_busy   = 1'b1;
               w_cnt    = L_SETTLE;
               w_shadow = '0;
            end
         end
         S_SETTLE: begin
            w_cnt   = r_cnt - 4'd1;
            w_state = (r_cnt <= 4'd1) ? S_SAMPLE : S_SETTLE;
         end
         S_SAMPLE: begin
            w_shadow[r_sel] = bus.mux_o;
            w_cnt           = L_SETTLE;
            if (r_sel != 3'd7) begin
               w_sel   = r_sel + 3'd1;
               w_state = L_FIRST;
            end else begin
               // Final bit goes straight into word; shadow only holds bits 0..6 here.
               w_word   = {bus.mux_o, r_shadow[6:0]};
               w_valid  = 1'b1;
               w_scan   = r_scan + 8'd1;
               w_sel    = '0;
               w_shadow = '0;
               w_state  = bus.cont ? L_FIRST : S_IDLE;
               w_busy   = bus.cont;
            end
         end
         default: w_state = S_IDLE;
      endcase
      if (r_state != S_IDLE && bus.abort) begin
         w_state  = S_IDLE;
         w_sel    = '0;
         w_busy   = 1'b0;
         w_cnt    = '0;
         w_shadow = '0;
         w_word   = r_word;
         w_valid  = 1'b0;
         w_scan   = r_scan;
      end
   end
   assign bus.sel        = r_sel;
   assign bus.busy       = r_busy;
   assign bus.word       = r_word;
   assign bus.word_valid = r_valid;
   assign bus.scan_cnt   = r_scan;
endmodule

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: directed checks of scan timing, continuous mode, abort, reset and count wrap.
module tb_mux_scan_capture;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] r_d = 8'h4D;
   int         checks = 0;
   int         failures = 0;
   mux_scan_capture_if ifc0 ();
   mux_scan_capture_if ifc2 ();
   assign ifc0.mux_o = r_d[ifc0.sel];
   assign ifc2.mux_o = r_d[ifc2.sel];
   mux_scan_capture #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
   mux_scan_capture #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk0(input string tag, input logic [2:0] sel, input logic busy,
                       input logic [7:0] word, input logic vld, input logic [7:0] cnt);
      chk({tag, "_sel"}, 32'(ifc0.sel), 32'(sel));
      chk({tag, "_busy"}, 32'(ifc0.busy), 32'(busy));
      chk({tag, "_word"}, 32'(ifc0.word), 32'(word));
      chk({tag, "_vld"}, 32'(ifc0.word_valid), 32'(vld));
      chk({tag, "_cnt"}, 32'(ifc0.scan_cnt), 32'(cnt));
   endtask
   initial begin
      ifc0.start = 0; ifc0.cont = 0; ifc0.abort = 0;
      ifc2.start = 0; ifc2.cont = 0; ifc2.abort = 0;
      tick(); tick();
      rst = 1'b0;
      chk0("reset", 3'd0, 1'b0, 8'h00, 1'b0, 8'd0);
      chk("reset2_busy", 32'(ifc2.busy), 32'd0);
      // SETTLE=2: each select held three cycles
      ifc2.start = 1; tick(); ifc2.start = 0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 3; j++) begin
            chk("s2_sel", 32'(ifc2.sel), 32'(k));
            chk("s2_busy", 32'(ifc2.busy), 32'd1);
            chk("s2_vld", 32'(ifc2.word_valid), 32'd0);
            tick();
         end
      chk("s2_word", 32'(ifc2.word), 32'h4D);
      chk("s2_vld_end", 32'(ifc2.word_valid), 32'd1);
      chk("s2_busy_end", 32'(ifc2.busy), 32'd0);
      chk("s2_cnt", 32'(ifc2.scan_cnt), 32'd1);
      // SETTLE=0 single scan, with a start pulse while busy that must be ignored
      ifc0.start = 1; tick(); ifc0.start = 0;
      for (int k = 0; k < 8; k++) begin
         chk0("scan1", 3'(k), 1'b1, 8'h00, 1'b0, 8'd0);
         ifc0.start = (k == 3);
         tick();
      end
      ifc0.start = 0;
      chk0("scan1_end", 3'd0, 1'b0, 8'h4D, 1'b1, 8'd1);
      tick();
      chk0("scan1_idle", 3'd0, 1'b0, 8'h4D, 1'b0, 8'd1);
      // continuous mode: back-to-back scans, cont dropped mid second scan
      ifc0.cont = 1; ifc0.start = 1; tick(); ifc0.start = 0;
      repeat (8) tick();
      chk0("cont1_end", 3'd0, 1'b1, 8'h4D, 1'b1, 8'd2);
      r_d = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         chk0("cont2", 3'(k), 1'b1, 8'h4D, k == 0, 8'd2);
         ifc0.cont = (k < 4);
         tick();
      end
      chk0("cont2_end", 3'd0, 1'b0, 8'hFF, 1'b1, 8'd3);
      // abort at sel==4 together with start
      r_d = 8'h4D;
      ifc0.start = 1; tick(); ifc0.start = 0;
      repeat (4) tick();
      chk0("pre_abort", 3'd4, 1'b1, 8'hFF, 1'b0, 8'd3);
      ifc0.abort = 1; ifc0.start = 1; tick();
      chk0("abort", 3'd0, 1'b0, 8'hFF, 1'b0, 8'd3);
      tick();
      chk0("abort_start_idle", 3'd0, 1'b0, 8'hFF, 1'b0, 8'd3);
      ifc0.abort = 0; ifc0.start = 0;
      repeat (9) tick();
      chk0("abort_quiet", 3'd0, 1'b0, 8'hFF, 1'b0, 8'd3);
      // abort on the final sample edge wins
      ifc0.start = 1; tick(); ifc0.start = 0;
      repeat (7) tick();
      chk0("pre_abort7", 3'd7, 1'b1, 8'hFF, 1'b0, 8'd3);
      ifc0.abort = 1; tick(); ifc0.abort = 0;
      chk0("abort7", 3'd0, 1'b0, 8'hFF, 1'b0, 8'd3);
      tick();
      chk0("abort7_quiet", 3'd0, 1'b0, 8'hFF, 1'b0, 8'd3);
      // reset at sel==5
      ifc0.start = 1; tick(); ifc0.start = 0;
      repeat (5) tick();
      chk0("pre_rst", 3'd5, 1'b1, 8'hFF, 1'b0, 8'd3);
      rst = 1; ifc0.start = 1; ifc0.cont = 1; tick(); rst = 0; ifc0.start = 0; ifc0.cont = 0;
      chk0("mid_rst", 3'd0, 1'b0, 8'h00, 1'b0, 8'd0);
      ifc0.start = 1; tick(); ifc0.start = 0;
      repeat (8) tick();
      chk0("post_rst_scan", 3'd0, 1'b0, 8'h4D, 1'b1, 8'd1);
      // 256 continuous scans wrap the counter
      rst = 1; tick(); rst = 0;
      ifc0.cont = 1; ifc0.start = 1; tick(); ifc0.start = 0;
      for (int n = 1; n <= 256; n++) begin
         repeat (8) tick();
         chk("wrap_vld", 32'(ifc0.word_valid), 32'd1);
         chk("wrap_busy", 32'(ifc0.busy), 32'd1);
         if (n >= 255) chk("wrap_cnt", 32'(ifc0.scan_cnt), 32'(n & 8'hFF));
      end
      ifc0.cont = 0;
      repeat (8) tick();
      chk0("wrap_stop", 3'd0, 1'b0, 8'h4D, 1'b1, 8'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
